// File: rtl/mem_pkg.sv
// Shared constants for the data-memory responder: RV32I load/store funct3 codes,
// FSM state encoding and the byte-lane mask helper.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   // funct3[1:0] encodes the access size; 2'b11 has no legal meaning.
   function automatic logic [3:0] lane_mask(input logic [1:0] size_code);
      logic [3:0] mask;
      case (size_code)
         2'd0:    mask = 4'b0001;
         2'd1:    mask = 4'b0011;
         2'd2:    mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/dmem_sram.sv
// Byte-addressed data SRAM with four byte lanes at consecutive (wrapping)
// addresses, synchronous per-lane write and registered 4-byte read.
module dmem_sram #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 65536
) (
   input  logic              clk,
   input  logic [3:0]        we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] lane_addr [4];
   logic [31:0]       rdata_q;

   // Lane k sits at addr+k; the ADDR_W-bit sum wraps past DEPTH-1 to 0.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_addr[gi] = addr_i + ADDR_W'(gi);
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (we_i[k]) begin
            mem[lane_addr[k]] <= wdata_i[8*k +: 8];
         end
         if (re_i) begin
            rdata_q[8*k +: 8] <= mem[lane_addr[k]];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked RV32I load/store responder in front of dmem_sram.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   logic [1:0]        state_q, state_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic [31:0]       wdata_q;

   logic              accept;
   logic              illegal;
   logic              misalign;
   logic              err;
   logic [3:0]        sram_we;
   logic              sram_re;
   logic [31:0]       sram_rdata;
   logic [31:0]       load_ext;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W];

   assign req_ready = (state_q == S_IDLE) && rst;
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_ACCESS;
         S_ACCESS: state_d = S_RESP;
         S_RESP:   if (rsp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         funct3_q <= '0;
         wdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q     <= req_we;
            addr_q   <= req_addr[ADDR_W-1:0];
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
         end
      end
   end

   assign illegal = we_q ? (funct3_q > F3_W)
                         : (funct3_q[1:0] == 2'b11) || (funct3_q == 3'b110);

`ifdef MISALIGN_TRAP_EN
   assign misalign = ((funct3_q[1:0] == 2'd1) && addr_q[0]) ||
                     ((funct3_q[1:0] == 2'd2) && (addr_q[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign err = illegal || misalign;

   // The SRAM is only touched on the single ACCESS edge, so a reset before it drops the whole store.
   assign sram_we = (state_q == S_ACCESS && we_q && !err) ? lane_mask(funct3_q[1:0]) : 4'b0000;
   assign sram_re = (state_q == S_ACCESS) && !we_q && !err;

   dmem_sram #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) sram (
      .clk     (clk),
      .we_i    (sram_we),
      .re_i    (sram_re),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (sram_rdata)
   );

   always_comb begin
      load_ext = sram_rdata;
      case (funct3_q)
         F3_B:    load_ext = {{24{sram_rdata[7]}}, sram_rdata[7:0]};
         F3_H:    load_ext = {{16{sram_rdata[15]}}, sram_rdata[15:0]};
         F3_BU:   load_ext = {24'd0, sram_rdata[7:0]};
         F3_HU:   load_ext = {16'd0, sram_rdata[15:0]};
         default: load_ext = sram_rdata;
      endcase
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_err   = rsp_valid && err;
   assign rsp_rdata = (rsp_valid && !we_q && !err) ? load_ext : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;
   import mem_pkg::*;

   localparam int DEPTH = 65536;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: bytes little-endian at (addr+k) mod DEPTH, extension by arithmetic.
   function automatic void model_txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                     input logic [31:0] wdata, output logic [31:0] rdata,
                                     output logic err);
      int nbytes;
      int a;
      longint unsigned v;
      a      = int'(addr[15:0]);
      nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err    = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef MISALIGN_TRAP_EN
      if ((a % nbytes) != 0) err = 1'b1;
`endif
      rdata = 32'd0;
      if (err) return;
      if (we) begin
         for (int k = 0; k < nbytes; k++) model_mem[(a + k) % DEPTH] = wdata[8*k +: 8];
      end else begin
         v = 0;
         for (int k = 0; k < nbytes; k++) v = v | (longint'(model_mem[(a + k) % DEPTH]) << (8 * k));
         if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v - (64'd1 << (8 * nbytes));
         rdata = v[31:0];
      end
   endfunction

   task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] wdata, input int hold, input bit poke, input string tag);
      logic [31:0] exp_rd;
      logic        exp_err;
      model_txn(we, addr, f3, wdata, exp_rd, exp_err);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_funct3 = f3;
      req_wdata  = wdata;
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = poke;
      if (poke) begin
         req_we     = 1'b1;
         req_funct3 = F3_W;
         req_wdata  = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      check({tag, ".early_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".rdata"}, rsp_rdata, exp_rd);
      check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
         check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, ".post_ready"}, 32'(req_ready), 32'd1);
      $display("txn %-10s we=%0d addr=%08h f3=%0d wdata=%08h -> exp rdata=%08h err=%0d",
               tag, we, addr, f3, wdata, exp_rd, exp_err);
   endtask

   task automatic check_mem(input string tag, input int a);
      check(tag, 32'(dut.sram.mem[a]), 32'(model_mem[a]));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r_hi;
      logic [31:0] r_addr;
      logic [2:0]  r_f3;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

      repeat (2) @(negedge clk);
      check("rst.req_ready", 32'(req_ready), 32'd0);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.rsp_rdata", rsp_rdata, 32'd0);
      check("rst.rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b1;

      txn(1'b1, 32'h1000, F3_W, 32'h0000_000A, 0, 1'b0, "t1_sw");
      txn(1'b0, 32'h1000, F3_W, 32'h0, 0, 1'b0, "t1_lw");
      check("t1.mem1000", 32'(dut.sram.mem[32'h1000]), 32'h0A);
      check("t1.mem1001", 32'(dut.sram.mem[32'h1001]), 32'h00);
      check("t1.mem1002", 32'(dut.sram.mem[32'h1002]), 32'h00);
      check("t1.mem1003", 32'(dut.sram.mem[32'h1003]), 32'h00);

      txn(1'b1, 32'h2000, F3_W, 32'h80FF_7F01, 0, 1'b0, "t2_sw");
      txn(1'b0, 32'h2002, F3_B, 32'h0, 0, 1'b0, "t2_lb");
      txn(1'b0, 32'h2002, F3_BU, 32'h0, 0, 1'b0, "t2_lbu");
      txn(1'b0, 32'h2002, F3_H, 32'h0, 1, 1'b0, "t2_lh");
      txn(1'b0, 32'h2000, F3_HU, 32'h0, 0, 1'b0, "t2_lhu");

      txn(1'b1, 32'h1004, F3_W, 32'h1122_3344, 0, 1'b0, "t3_sw");
      txn(1'b1, 32'h1005, F3_B, 32'h0000_0014, 0, 1'b0, "t3_sb");
      txn(1'b0, 32'h1004, F3_W, 32'h0, 0, 1'b0, "t3_lw");

      // A store request held during RESP must be ignored.
      txn(1'b0, 32'h1000, F3_W, 32'h0, 5, 1'b1, "t4_hold");
      for (int k = 0; k < 4; k++) check_mem("t4.mem", 32'h1000 + k);

      txn(1'b0, 32'h1002, F3_W, 32'h0, 0, 1'b0, "t5_lw_mis");
      txn(1'b0, 32'h1003, F3_H, 32'h0, 0, 1'b0, "t5_lh_mis");

      txn(1'b1, 32'h1004, 3'd3, 32'hCAFE_BABE, 0, 1'b0, "t6_bad_st");
      txn(1'b1, 32'h1004, 3'd7, 32'hCAFE_BABE, 0, 1'b0, "t6_bad_st7");
      txn(1'b0, 32'h1004, 3'd6, 32'h0, 0, 1'b0, "t6_bad_ld");
      for (int k = 0; k < 4; k++) check_mem("t6.mem", 32'h1004 + k);

      txn(1'b1, 32'h3000, F3_W, 32'h5A5A_5A5A, 0, 1'b0, "t6_sw");
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3000;
      req_funct3 = F3_W; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("t6.rst_valid", 32'(rsp_valid), 32'd0);
      check("t6.rst_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6.idle_ready", 32'(req_ready), 32'd1);
      check("t6.idle_valid", 32'(rsp_valid), 32'd0);
      for (int k = 0; k < 4; k++) check_mem("t6.drop_mem", 32'h3000 + k);
      $display("txn %-10s reset during ACCESS of SW 3000", "t6_drop");
      txn(1'b0, 32'h3000, F3_W, 32'h0, 0, 1'b0, "t6_lw");

      // Seed both sides of the wrap point so random loads only see known bytes.
      for (int i = 0; i < 16; i++) begin
         txn(1'b1, 32'hFFC0 + 32'(4 * i), F3_W, $urandom, 0, 1'b0, "init_hi");
         txn(1'b1, 32'h0000 + 32'(4 * i), F3_W, $urandom, 0, 1'b0, "init_lo");
      end

      for (int i = 0; i < 150; i++) begin
         r_hi   = $urandom;
         r_addr = 32'h0000_FFF0 + 32'($urandom_range(0, 39));
         r_addr = {r_hi[31:16], r_addr[15:0]};
         r_f3   = 3'($urandom_range(0, 7));
         txn(($urandom_range(0, 2) == 0), r_addr, r_f3, $urandom,
             int'($urandom_range(0, 3)), 1'b0, "rand");
      end

      for (int a = 0; a < 64; a++) begin
         check_mem("final.lo", a);
         check_mem("final.hi", 32'hFFC0 + a);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
